// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core
//   Multicycle RV64I-subset core: PC, IR, 32-entry register file, A/B/ALUOut/MDR
//   holding registers, an ALU and the control FSM. Instruction and data
//   memories are external and reached over req/ready handshakes, so wait-state
//   memories stall the core in FETCH / MEM_LD / MEM_ST.
//
//   Supported: ADD SUB AND OR SLT ADDI LD SD BEQ BNE JAL. Anything else halts.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   imem_req/addr     fetch request, address = PC
//   imem_ready/rdata  fetch accepted, instruction word valid that cycle
//   dmem_req/we/addr  data request, 1 = store, byte address from ALUOut
//   dmem_wdata        store data (B register)
//   dmem_ready/rdata  access accepted, load data valid that cycle
//   pc_out            current PC
//   retired           one-cycle pulse per completed instruction
//   halted            sticky until reset
//
// Build option
//   CORE_MISALIGN_TRAP_EN: misaligned LD/SD halts from ADDR without touching
//   memory. Without it, address bits [2:0] are cleared and the access proceeds.
module riscv_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [PC_W-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [PC_W-1:0] pc_out,
    output logic            retired,
    output logic            halted
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_LD, S_WB_LD,
        S_MEM_ST, S_WB_ALU, S_BRANCH, S_JAL, S_HALT
    } state_t;

    state_t state, state_next;

    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] a, b, alu_out, mdr;
    logic [XLEN-1:0] regs [32];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic is_r, is_addi, is_ld, is_sd, is_br, is_jal;
    assign is_r    = (opcode == OP_R) &&
                     (((f7 == 7'b0000000) && ((f3 == 3'b000) || (f3 == 3'b111) ||
                                              (f3 == 3'b110) || (f3 == 3'b010))) ||
                      ((f7 == 7'b0100000) && (f3 == 3'b000)));
    assign is_addi = (opcode == OP_IMM)    && (f3 == 3'b000);
    assign is_ld   = (opcode == OP_LOAD)   && (f3 == 3'b011);
    assign is_sd   = (opcode == OP_STORE)  && (f3 == 3'b011);
    assign is_br   = (opcode == OP_BRANCH) && ((f3 == 3'b000) || (f3 == 3'b001));
    assign is_jal  = (opcode == OP_JAL);

    // PC has already advanced past this instruction by DECODE.
    logic [PC_W-1:0] pc_old;
    assign pc_old = pc - PC_W'(4);

    logic [XLEN-1:0] addr_sum, target;
    logic            br_taken, misaligned;
    assign addr_sum = a + (is_sd ? imm_s : imm_i);
    assign target   = XLEN'(pc_old) + (is_jal ? imm_j : imm_b);
    assign br_taken = (f3 == 3'b000) ? (a == b) : (a != b);

`ifdef CORE_MISALIGN_TRAP_EN
    assign misaligned = (addr_sum[2:0] != 3'b000);
    assign dmem_addr  = alu_out[PC_W-1:0];
`else
    assign misaligned = 1'b0;
    assign dmem_addr  = {alu_out[PC_W-1:3], 3'b000};
`endif

    function automatic logic [XLEN-1:0] alu_r(input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y,
                                              input logic [2:0]      op,
                                              input logic            sub);
        logic signed [XLEN-1:0] xs, ys;
        xs = x;
        ys = y;
        case (op)
            3'b000:  alu_r = sub ? (x - y) : (x + y);
            3'b111:  alu_r = x & y;
            3'b110:  alu_r = x | y;
            3'b010:  alu_r = (xs < ys) ? XLEN'(1) : '0;
            default: alu_r = '0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (imem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (is_r)                      state_next = S_EXEC_R;
                else if (is_addi)              state_next = S_EXEC_I;
                else if (is_ld || is_sd)       state_next = S_ADDR;
                else if (is_br)                state_next = S_BRANCH;
                else if (is_jal)               state_next = S_JAL;
                else                           state_next = S_HALT;
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_ADDR: begin
                if (misaligned)  state_next = S_HALT;
                else if (is_sd)  state_next = S_MEM_ST;
                else             state_next = S_MEM_LD;
            end
            S_MEM_LD: if (dmem_ready) state_next = S_WB_LD;
            S_MEM_ST: if (dmem_ready) state_next = S_FETCH;
            S_WB_LD, S_WB_ALU, S_BRANCH, S_JAL: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    // Outputs. imem_req is qualified by reset so the fetch request stays low
    // while reset is held and rises in the first cycle after release.
    always_comb begin
        imem_req = reset && (state == S_FETCH);
        dmem_req = (state == S_MEM_LD) || (state == S_MEM_ST);
        dmem_we  = (state == S_MEM_ST);
        retired  = (state == S_WB_ALU) || (state == S_WB_LD) || (state == S_BRANCH) ||
                   (state == S_JAL) || ((state == S_MEM_ST) && dmem_ready);
        halted   = (state == S_HALT);
    end

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_wdata = b;

    // Datapath registers and register file
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (imem_ready) begin
                    ir <= imem_rdata;
                    pc <= pc + PC_W'(4);
                end
                S_DECODE: begin
                    a       <= regs[rs1];
                    b       <= regs[rs2];
                    alu_out <= target;
                end
                S_EXEC_R: alu_out <= alu_r(a, b, f3, f7[5]);
                S_EXEC_I: alu_out <= a + imm_i;
                S_ADDR:   alu_out <= addr_sum;
                S_MEM_LD: if (dmem_ready) mdr <= dmem_rdata;
                S_WB_ALU: if (rd != 5'd0) regs[rd] <= alu_out;
                S_WB_LD:  if (rd != 5'd0) regs[rd] <= mdr;
                S_BRANCH: if (br_taken) pc <= alu_out[PC_W-1:0];
                S_JAL: begin
                    if (rd != 5'd0) regs[rd] <= XLEN'(pc);
                    pc <= alu_out[PC_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/riscv_multicycle_core.md
# riscv_multicycle_core

Parametrised multicycle RV64I-subset core: datapath plus integrated control FSM, with PC, IR, 32-entry register file, A/B/ALUOut/MDR holding registers, and an ALU. Instruction and data memories are external, reached over req/ready handshakes so wait-state memories can stall the core. Sits at the top of the processor hierarchy, replacing the hand-wired datapath and its separately driven control flags.

## Interface
- XLEN, 64, datapath and register width (32 or 64)
- PC_W, 32, PC and memory address width (≤ XLEN)
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset; one clock; reset is synchronous and active-low
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ready  in  1  fetch accepted; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  PC_W  byte address = ALUOut[PC_W-1:0]
- dmem_wdata  out  XLEN  store data (= B register)
- dmem_ready  in  1  access accepted; dmem_rdata valid this cycle (loads)
- dmem_rdata  in  XLEN  load data
- pc_out  out  PC_W  current PC
- retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  core stopped (sticky until reset)

## Operation
- Supported: ADD/SUB/AND/OR/SLT (0110011), ADDI (0010011), LD (0000011, f3=011), SD (0100011, f3=011), BEQ/BNE (1100011), JAL (1101111). Any other encoding, incl. ECALL/EBREAK -> HALT.
- States: FETCH -> DECODE -> {EXEC_R, EXEC_I, ADDR, BRANCH, JAL} ; EXEC_R/EXEC_I -> WB_ALU -> FETCH ; ADDR -> MEM_LD -> WB_LD -> FETCH or ADDR -> MEM_ST -> FETCH ; BRANCH, JAL -> FETCH ; HALT absorbing.
- FETCH: imem_req=1 held with stable addr until imem_ready; on ready IR<=imem_rdata, PC<=PC+4.
- DECODE: A<=rs1, B<=rs2, ALUOut<=oldPC+imm (branch/jump target; oldPC = PC-4).
- MEM_LD/MEM_ST: dmem_req=1 held until dmem_ready; load data captured to MDR on ready.
- BRANCH: compare A,B; if taken PC<=ALUOut. JAL: rd<=PC (already +4), PC<=ALUOut.
- Immediates: I/S/B/J sign-extended to XLEN; B/J immediates are byte offsets (bit 0 = 0).
- Arithmetic modulo 2^XLEN; SLT signed; PC wraps modulo 2^PC_W.
- x0 reads 0; writes to x0 discarded.
- retired pulses in the last state of each instruction (WB_ALU, WB_LD, MEM_ST on ready, BRANCH, JAL); never for a HALT-ing instruction.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IR/A/B/ALUOut/MDR=0, all regs=0, imem_req=dmem_req=dmem_we=0, retired=0, halted=0. imem_req rises first cycle after reset release.
- Latency with zero-wait memory (ready in first req cycle): R/ADDI 4 cycles, LD 5, SD 4, BEQ/BNE 3, JAL 3. Each wait cycle adds one.
- Req never deasserts before ready; addr/we/wdata stable throughout.
- imem_req and dmem_req never high together.
- Reset asserted mid-access: req drops on next edge; pending access abandoned, no state written.
- halted rises the cycle after DECODE of illegal opcode; all req outputs 0 thereafter.

## Configuration
- CORE_MISALIGN_TRAP_EN defined: LD/SD with address[2:0]≠0 -> HALT from ADDR, no dmem_req issued, no retire. Undefined: address[2:0] forced to 0 on dmem_addr, access proceeds.

## Test plan
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 zero-wait -> x3=2, three retired pulses, 12 cycles total.
- SD x3,8(x0) then LD x4,8(x0) with 2 wait cycles on dmem -> dmem_addr=8, dmem_wdata=2, x4=2, req held 3 cycles each.
- BEQ x1,x1,-8 at PC 0x10 -> PC=0x08 after 3 cycles; BNE x1,x1 same -> PC=0x14.
- JAL x5,+16 at PC 0x20 -> x5=0x24, PC=0x30; ADDI x0,x0,7 -> x0 remains 0.
- Opcode 0x73 (ECALL) -> halted=1, no retire, no further imem_req; reset low one cycle -> PC=RESET_PC, halted=0.
- LD at address 0x0C: with CORE_MISALIGN_TRAP_EN -> halted, no dmem_req; without -> dmem_addr=0x08.
